// File: rtl/shift_sequencer_if.sv
// Handshake bundle between the button synchronizers / register units and shift_sequencer.
// The sequencer uses the slave modport; the button/register side uses master.
interface shift_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             LoadA;
  logic             LoadB;
  logic             Execute;
  logic [1:0]       Passes;
  logic             Shift_En;
  logic             Ld_A;
  logic             Ld_B;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] Count;

  modport master (
    output LoadA, LoadB, Execute, Passes,
    input  Shift_En, Ld_A, Ld_B, Busy, Done, Count
  );

  modport slave (
    input  LoadA, LoadB, Execute, Passes,
    output Shift_En, Ld_A, Ld_B, Busy, Done, Count
  );
endinterface

// File: rtl/shift_sequencer.sv
// Shift-datapath sequencer: load strobes from button edges and a WIDTH*(Passes+1) shift burst.
// Optional macro SHIFT_SEQ_AUTOREARM_EN: skip HOLD and restart while Execute stays high.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic             Clk,
  input logic             Reset,
  shift_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
`ifdef SHIFT_SEQ_AUTOREARM_EN
  localparam state_t END_STATE = IDLE;
`else
  localparam state_t END_STATE = HOLD;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       pass_left_q;
  logic             prev_a, prev_b;
  logic             ld_a_q, ld_b_q, done_q;
  logic             last_shift;
  logic             load_ok;

  // Final shift cycle of the final pass; Done is registered from this.
  assign last_shift = (state_q == SHIFT) && (count_q == LAST) && (pass_left_q == 2'd0);
  // Loads only honoured in IDLE, and Execute wins over a simultaneous load edge.
  assign load_ok    = (state_q == IDLE) && !bus.Execute;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default first so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.Execute) state_d = SHIFT;
      SHIFT:   if (last_shift)  state_d = END_STATE;
      HOLD:    if (!bus.Execute) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q     <= '0;
      pass_left_q <= 2'd0;
      prev_a      <= 1'b0;
      prev_b      <= 1'b0;
      ld_a_q      <= 1'b0;
      ld_b_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      prev_a <= bus.LoadA;
      prev_b <= bus.LoadB;
      ld_a_q <= load_ok && bus.LoadA && !prev_a;
      ld_b_q <= load_ok && bus.LoadB && !prev_b;
      done_q <= last_shift;
      unique case (state_q)
        IDLE: begin
          count_q <= '0;
          if (bus.Execute) pass_left_q <= bus.Passes;
        end
        SHIFT: begin
          if (count_q != LAST) begin
            count_q <= count_q + CNT_W'(1);
          end else if (pass_left_q != 2'd0) begin
            // Wrap into the next pass without a gap in Shift_En.
            count_q     <= '0;
            pass_left_q <= pass_left_q - 2'd1;
          end else if (END_STATE == IDLE) begin
            count_q <= '0;
          end
        end
        HOLD: begin
          if (!bus.Execute) count_q <= '0;
        end
        default: count_q <= '0;
      endcase
    end
  end

  always_comb begin
    bus.Shift_En = (state_q == SHIFT);
    bus.Busy     = (state_q == SHIFT);
    bus.Ld_A     = ld_a_q;
    bus.Ld_B     = ld_b_q;
    bus.Done     = done_q;
    bus.Count    = count_q;
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed steps with randomized passes, release
// points and button patterns, expectations derived from run-length arithmetic and edge rules.
module tb_shift_sequencer;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  shift_sequencer_if #(.CNT_W(CNT_W)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input int cnt);
    check({tag, "_shift_en"}, bus.Shift_En, 0);
    check({tag, "_busy"},     bus.Busy,     0);
    check({tag, "_done"},     bus.Done,     0);
    check({tag, "_ld_a"},     bus.Ld_A,     0);
    check({tag, "_ld_b"},     bus.Ld_B,     0);
    check({tag, "_count"},    bus.Count,    cnt);
  endtask

  // One run from IDLE: Execute rises with Passes=p; Execute drops after run cycle rel
  // (rel > run length means it is still held when the run ends).
  task automatic do_run(input int p, input int rel, input bit loads, input bit with_load);
    int n;
    n = WIDTH * (p + 1);
    bus.Passes  = 2'(p);
    bus.Execute = 1'b1;
    if (with_load) bus.LoadA = 1'b1;
    tick();
    for (int i = 1; i <= n; i++) begin
      check("run_shift_en", bus.Shift_En, 1);
      check("run_busy",     bus.Busy,     1);
      check("run_count",    bus.Count,    (i - 1) % WIDTH);
      check("run_done",     bus.Done,     0);
      check("run_ld_a",     bus.Ld_A,     0);
      check("run_ld_b",     bus.Ld_B,     0);
      bus.Passes = 2'($urandom);
      if (loads) begin
        bus.LoadA = 1'($urandom);
        bus.LoadB = 1'($urandom);
      end
      if (i == rel) bus.Execute = 1'b0;
      tick();
    end
    check("end_done",     bus.Done,     1);
    check("end_shift_en", bus.Shift_En, 0);
    check("end_busy",     bus.Busy,     0);
    check("end_ld_a",     bus.Ld_A,     0);
    check("end_ld_b",     bus.Ld_B,     0);
`ifdef SHIFT_SEQ_AUTOREARM_EN
    check("end_count", bus.Count, 0);
    bus.Execute = 1'b0;
    tick();
    check_quiet("post", 0);
`else
    check("end_count", bus.Count, WIDTH - 1);
    if (rel > n) begin
      repeat (3) begin
        tick();
        check_quiet("hold", WIDTH - 1);
      end
      bus.Execute = 1'b0;
    end
    tick();
    check_quiet("post", 0);
`endif
    bus.LoadA = 1'b0;
    bus.LoadB = 1'b0;
    tick();
    check_quiet("clean", 0);
  endtask

  // Random button levels in IDLE; a strobe is expected exactly on a 0->1 change.
  task automatic load_pattern(input int cycles);
    bit pa, pb, a, b;
    pa = bus.LoadA;
    pb = bus.LoadB;
    for (int i = 0; i < cycles; i++) begin
      a = 1'($urandom);
      b = 1'($urandom);
      bus.LoadA = a;
      bus.LoadB = b;
      tick();
      check("pat_ld_a", bus.Ld_A, (a && !pa) ? 1 : 0);
      check("pat_ld_b", bus.Ld_B, (b && !pb) ? 1 : 0);
      check("pat_busy", bus.Busy, 0);
      pa = a;
      pb = b;
    end
    bus.LoadA = 1'b0;
    bus.LoadB = 1'b0;
    tick();
  endtask

  initial begin
    int strobes;
    rst         = 1'b1;
    bus.LoadA   = 1'b1;
    bus.LoadB   = 1'b0;
    bus.Execute = 1'b0;
    bus.Passes  = 2'd0;
    #3;
    check_quiet("reset", 0);

    // LoadA held through reset release and for 10 cycles: one strobe, after the first edge.
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("held_first_ld_a", bus.Ld_A, 1);
    strobes = 1;
    repeat (9) begin
      tick();
      if (bus.Ld_A === 1'b1) strobes++;
    end
    check("held_strobe_count", strobes, 1);
    bus.LoadA = 1'b0;
    tick();

    // Simultaneous rising edges give both strobes together.
    bus.LoadA = 1'b1;
    bus.LoadB = 1'b1;
    tick();
    check("both_ld_a", bus.Ld_A, 1);
    check("both_ld_b", bus.Ld_B, 1);
    tick();
    check("both_ld_a_drop", bus.Ld_A, 0);
    check("both_ld_b_drop", bus.Ld_B, 0);
    bus.LoadA = 1'b0;
    bus.LoadB = 1'b0;
    tick();

    do_run(0, 20, 1'b0, 1'b0);   // single pass, Execute held long
    do_run(3, 1, 1'b1, 1'b0);    // four passes, short press, loads during run
    do_run(0, 3, 1'b0, 1'b1);    // Execute and LoadA rise together
    // LoadB rising mid-run and still high afterwards: never strobes.
    bus.Passes  = 2'd0;
    bus.Execute = 1'b1;
    tick();
    bus.Execute = 1'b0;
    tick();
    bus.LoadB = 1'b1;
    for (int i = 0; i < WIDTH + 4; i++) begin
      tick();
      check("late_ld_b", bus.Ld_B, 0);
    end
    bus.LoadB = 1'b0;
    tick();

    repeat (4) begin
      do_run(int'($urandom_range(0, 3)), int'($urandom_range(1, 40)), 1'b1,
             1'($urandom_range(0, 1)));
      load_pattern(12);
    end

    // Reset during shift cycle 5: outputs clear at once, no Done afterwards.
    bus.Passes  = 2'd0;
    bus.Execute = 1'b1;
    tick();
    repeat (4) tick();
    check("pre_rst_count", bus.Count, 4);
    check("pre_rst_shift", bus.Shift_En, 1);
    #2;
    rst = 1'b1;
    #1;
    check_quiet("async_rst", 0);
    bus.Execute = 1'b0;
    rst = 1'b0;
    repeat (WIDTH) begin
      tick();
      check_quiet("after_rst", 0);
    end
    bus.LoadA = 1'b1;
    tick();
    check("after_rst_idle_ld_a", bus.Ld_A, 1);
    bus.LoadA = 1'b0;
    tick();

    // Execute held through reset release starts a run.
    rst = 1'b1;
    bus.Execute = 1'b1;
    #2;
    rst = 1'b0;
    do_run(0, 2, 1'b0, 1'b0);

`ifdef SHIFT_SEQ_AUTOREARM_EN
    // Held Execute: back-to-back runs, one IDLE cycle apart, Done in that cycle.
    bus.Passes  = 2'd0;
    bus.Execute = 1'b1;
    tick();
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= WIDTH; i++) begin
        check("rearm_shift_en", bus.Shift_En, 1);
        check("rearm_count",    bus.Count,    i - 1);
        tick();
      end
      check("rearm_gap_shift", bus.Shift_En, 0);
      check("rearm_gap_done",  bus.Done,     1);
      if (r == 1) bus.Execute = 1'b0;
      tick();
    end
    check_quiet("rearm_stop", 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
